// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulation stage.
package prod_accum_pkg;

  localparam int BWOP_DEF = 32;
  localparam int ACCW_DEF = 40;
  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage : prod_accum_pkg

// File: rtl/prod_accum.sv
// Sums a programmed number of unsigned products into a wide accumulator and
// hands the result downstream over valid/ready, flagging any carry out.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int BWOP = BWOP_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BWOP-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data,
  output logic            out_ovf,
  output logic            busy
);

  state_e          r_state;
  state_e          w_next;
  logic [ACCW-1:0] r_acc;
  logic            r_ovf;
  logic [CNTW-1:0] r_rem;
  logic            w_take;
  logic [ACCW:0]   w_sum;

  assign w_take = (r_state == ACC) && in_valid;
  // One extra bit captures the carry out of the accumulator.
  assign w_sum  = {1'b0, r_acc} + {{(ACCW + 1 - BWOP){1'b0}}, in_data};

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset so every register reads 0 the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before any branch so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (start) w_next = (len == '0) ? HOLD : ACC;
        ACC:  if (w_take && (r_rem == CNTW'(1))) w_next = HOLD;
        HOLD: if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= '0;
    end else if (abort) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= len;
    end else if (w_take) begin
      r_acc <= w_sum[ACCW-1:0];
      r_ovf <= r_ovf | w_sum[ACCW];
      r_rem <= r_rem - CNTW'(1);
    end
  end

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;

endmodule : prod_accum

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: stimulus pushes expected results into a
// queue, a monitor pops and compares on every output handshake.
module tb_prod_accum;

  typedef struct {
    logic [63:0] data;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [39:0] out_data;

  logic        b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [7:0]  b_len = '0;
  logic [31:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [32:0] b_out_data;

  exp_t exp_q[$];
  exp_t b_exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prod_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  prod_accum #(.BWOP(32), .ACCW(33), .CNTW(8)) dut33 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len), .abort(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ovf(b_out_ovf), .busy(b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(out_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), e.data);
        check("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) begin
        check("unexpected_result_33", 64'(b_out_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = b_exp_q.pop_front();
        check("out_data_33", 64'(b_out_data), e.data);
        check("out_ovf_33", 64'(b_out_ovf), 64'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [63:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  initial begin
    logic        pat_v[6];
    logic [31:0] pat_d[6];
    exp_t        eb;
    pat_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pat_d = '{32'd1, 32'd99, 32'd2, 32'd99, 32'd3, 32'd4};

    // Reset values while rst_n is held.
    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_ovf", 64'(out_ovf), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Basic three-term sum.
    push(64'd21, 1'b0);
    go(8'd3);
    check("t1_busy", 64'(busy), 1);
    check("t1_in_ready", 64'(in_ready), 1);
    beat(32'd5);
    beat(32'd7);
    check("t1_no_early_valid", 64'(out_valid), 0);
    beat(32'd9);
    check("t1_out_valid", 64'(out_valid), 1);
    check("t1_in_ready_hold", 64'(in_ready), 0);
    step();
    check("t1_idle_valid", 64'(out_valid), 0);
    check("t1_idle_busy", 64'(busy), 0);

    // 33-bit accumulator wraps and flags overflow.
    eb.data = 64'h0FFFFFFFD;
    eb.ovf  = 1'b1;
    b_exp_q.push_back(eb);
    b_start = 1'b1;
    b_len   = 8'd3;
    step();
    b_start = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = 32'hFFFF_FFFF;
    repeat (3) step();
    b_in_valid = 1'b0;
    check("t2_out_valid_33", 64'(b_out_valid), 1);
    step();
    check("t2_idle_33", 64'(b_busy), 0);

    // Result held under back-pressure; start ignored meanwhile.
    out_ready = 1'b0;
    push(64'd7, 1'b0);
    go(8'd2);
    beat(32'd3);
    beat(32'd4);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(out_valid), 1);
      check("t3_hold_data", 64'(out_data), 7);
      check("t3_hold_in_ready", 64'(in_ready), 0);
      start = (i == 2);
      len   = 8'd5;
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    check("t3_idle_valid", 64'(out_valid), 0);
    check("t3_idle_busy", 64'(busy), 0);
    push(64'd6, 1'b0);
    go(8'd1);
    check("t3_restart_busy", 64'(in_ready), 1);
    beat(32'd6);
    step();

    // Zero-length accumulation.
    push(64'd0, 1'b0);
    go(8'd0);
    check("t4_out_valid", 64'(out_valid), 1);
    check("t4_in_ready", 64'(in_ready), 0);
    step();
    check("t4_idle", 64'(busy), 0);

    // Gaps in in_valid: only handshaken beats count.
    push(64'd10, 1'b0);
    go(8'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = pat_v[i];
      in_data  = pat_d[i];
      step();
    end
    in_valid = 1'b0;
    check("t5_out_valid", 64'(out_valid), 1);
    step();

    // Abort mid-accumulation discards the concurrent beat and the result.
    go(8'd4);
    beat(32'd1);
    beat(32'd2);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd50;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    check("t6_abort_busy", 64'(busy), 0);
    check("t6_abort_valid", 64'(out_valid), 0);
    check("t6_abort_acc", 64'(out_data), 0);
    repeat (3) begin
      check("t6_no_result", 64'(out_valid), 0);
      step();
    end

    // Abort beats an output handshake in HOLD.
    go(8'd1);
    beat(32'd8);
    check("t6_hold_before_abort", 64'(out_valid), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_abort_hold", 64'(out_valid), 0);

    // Asynchronous reset mid-accumulation.
    go(8'd4);
    beat(32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_in_ready", 64'(in_ready), 0);
    check("t6_rst_data", 64'(out_data), 0);
    step();
    rst_n = 1'b1;
    step();
    push(64'd4, 1'b0);
    go(8'd1);
    beat(32'd4);
    check("t6_final_valid", 64'(out_valid), 1);
    step();
    step();

    check("queue_empty", 64'(exp_q.size()), 0);
    check("queue_empty_33", 64'(b_exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

endmodule : tb_prod_accum
